// File: rtl/io_panel_pkg.sv
// io_panel_pkg
//   Shared definitions for the front-panel controller: seven-segment glyph
//   constants (bit order {g,f,e,d,c,b,a}, active-high), the blank pattern,
//   the hex decoder, the button event FSM state type and a counter-width
//   helper.
package io_panel_pkg;

   localparam logic [6:0] GLYPH_0   = 7'h3F;
   localparam logic [6:0] GLYPH_1   = 7'h06;
   localparam logic [6:0] GLYPH_2   = 7'h5B;
   localparam logic [6:0] GLYPH_3   = 7'h4F;
   localparam logic [6:0] GLYPH_4   = 7'h66;
   localparam logic [6:0] GLYPH_5   = 7'h6D;
   localparam logic [6:0] GLYPH_6   = 7'h7D;
   localparam logic [6:0] GLYPH_7   = 7'h07;
   localparam logic [6:0] GLYPH_8   = 7'h7F;
   localparam logic [6:0] GLYPH_9   = 7'h6F;
   localparam logic [6:0] GLYPH_A   = 7'h77;
   localparam logic [6:0] GLYPH_B   = 7'h7C;  // lowercase b
   localparam logic [6:0] GLYPH_C   = 7'h39;
   localparam logic [6:0] GLYPH_D   = 7'h5E;  // lowercase d
   localparam logic [6:0] GLYPH_E   = 7'h79;
   localparam logic [6:0] GLYPH_F   = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      EV_IDLE    = 2'd0,
      EV_PRESSED = 2'd1,
      EV_HELD    = 2'd2
   } ev_state_e;

   // Bits needed to hold values 0..term-1, never less than one bit.
   function automatic int cnt_width(input int term);
      return (term > 1) ? $clog2(term) : 1;
   endfunction

   function automatic logic [6:0] hex_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = GLYPH_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/io_panel_ctrl_btn_channel.sv
// btn_channel
//   One push-button channel: 2-flop synchroniser, debounce counter and the
//   press / long-press / auto-repeat event FSM. All outputs are registered.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     btn_i     - raw asynchronous button level (1 = pressed)
//     level_o   - debounced level
//     press_o   - one-cycle pulse on accepted press and on each repeat
//     long_o    - one-cycle pulse when the hold reaches LONG_CYC
//   Handshake: none; events are fire-and-forget single-cycle pulses.
module btn_channel
   import io_panel_pkg::*;
#(
   parameter int DB_CYC     = 2_000_000,
   parameter int LONG_CYC   = 100_000_000,
   parameter int REPEAT_CYC = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic long_o
);

   localparam int DB_W   = cnt_width(DB_CYC);
   localparam int HOLD_W = cnt_width((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

   logic              sync1_q, sync2_q;
   logic              stable_q, stable_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   ev_state_e         state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_q, press_d;
   logic              long_q, long_d;
   logic              rise, fall;

   // Debounce: count consecutive cycles the synchronised level disagrees
   // with the stable level; any agreeing cycle restarts the count.
   always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = ~stable_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   assign rise = stable_d & ~stable_q;
   assign fall = ~stable_d & stable_q;

   // Event FSM. Decisions use the next stable level so the press pulse
   // lands in the same cycle the debounced level changes.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      long_d  = 1'b0;
      case (state_q)
         EV_IDLE: begin
            hold_d = '0;
            if (rise) begin
               state_d = EV_PRESSED;
               press_d = 1'b1;
            end
         end
         EV_PRESSED: begin
            if (hold_q == LONG_LAST) begin
               state_d = EV_HELD;
               press_d = 1'b1;
               long_d  = 1'b1;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         EV_HELD: begin
            if (hold_q == REP_LAST) begin
               press_d = 1'b1;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = EV_IDLE;
            hold_d  = '0;
         end
      endcase
      // A release wins over any event due in the same cycle.
      if (fall) begin
         state_d = EV_IDLE;
         hold_d  = '0;
         press_d = 1'b0;
         long_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
         state_q  <= EV_IDLE;
         hold_q   <= '0;
         press_q  <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         press_q  <= press_d;
         long_q   <= long_d;
      end
   end

   assign level_o = stable_q;
   assign press_o = press_q;
   assign long_o  = long_q;

endmodule

// File: rtl/io_panel_ctrl.sv
// io_panel_ctrl
//   Front-panel controller: N_BTN debounced buttons with press / long-press /
//   auto-repeat events, and an N_DIG-digit multiplexed seven-segment display
//   with hex decode, per-digit decimal point, blanking and pin polarity.
//   Ports:
//     clk, rst     - clock, asynchronous active-high reset
//     btn_i        - raw button levels, 1 = pressed
//     seg_code_i   - digit k hex code at [4k+3:4k], digit 0 rightmost
//     dp_i         - decimal point request per digit
//     blank_i      - 1 = digit fully dark
//     btn_level_o  - debounced levels
//     btn_press_o  - press / repeat pulses
//     btn_long_o   - long-press pulses
//     seg_o        - segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//     dp_o         - decimal point, polarity per SEG_ACT_LOW
//     dig_o        - one-hot digit enable, polarity per DIG_ACT_LOW
module io_panel_ctrl
   import io_panel_pkg::*;
#(
   parameter int N_BTN       = 5,
   parameter int N_DIG       = 4,
   parameter int DB_CYC      = 2_000_000,
   parameter int LONG_CYC    = 100_000_000,
   parameter int REPEAT_CYC  = 20_000_000,
   parameter int SCAN_CYC    = 100_000,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_BTN-1:0]   btn_i,
   input  logic [4*N_DIG-1:0] seg_code_i,
   input  logic [N_DIG-1:0]   dp_i,
   input  logic [N_DIG-1:0]   blank_i,
   output logic [N_BTN-1:0]   btn_level_o,
   output logic [N_BTN-1:0]   btn_press_o,
   output logic [N_BTN-1:0]   btn_long_o,
   output logic [6:0]         seg_o,
   output logic               dp_o,
   output logic [N_DIG-1:0]   dig_o
);

   localparam int SCAN_W = cnt_width(SCAN_CYC);
   localparam int IDX_W  = cnt_width(N_DIG);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIG - 1);

   // XOR masks that turn active-high internal values into pin levels;
   // they are also the inactive pin levels used at reset.
   localparam logic [6:0]       SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic             DP_INV  = (SEG_ACT_LOW != 0);
   localparam logic [N_DIG-1:0] DIG_INV = (DIG_ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_channel #(
         .DB_CYC    (DB_CYC),
         .LONG_CYC  (LONG_CYC),
         .REPEAT_CYC(REPEAT_CYC)
      ) u_btn_channel (
         .clk    (clk),
         .rst    (rst),
         .btn_i  (btn_i[g]),
         .level_o(btn_level_o[g]),
         .press_o(btn_press_o[g]),
         .long_o (btn_long_o[g])
      );
   end

   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]  dig_idx_q, dig_idx_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [N_DIG-1:0]  dig_q, dig_d;
   logic [3:0]        cur_code;
   logic              cur_dp, cur_blank;
   logic [N_DIG-1:0]  dig_hot;
   logic [6:0]        seg_hi;

   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      dig_idx_d  = dig_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
      end
   end

   // Select the current digit's inputs with a compare loop so non-power-of-2
   // digit counts never form an out-of-range part select.
   always_comb begin
      cur_code  = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      dig_hot   = '0;
      for (int k = 0; k < N_DIG; k++) begin
         if (dig_idx_q == IDX_W'(k)) begin
            cur_code   = seg_code_i[4*k +: 4];
            cur_dp     = dp_i[k];
            cur_blank  = blank_i[k];
            dig_hot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      seg_hi = cur_blank ? SEG_BLANK : hex_decode(cur_code);
      seg_d  = seg_hi ^ SEG_INV;
      dp_d   = (cur_dp & ~cur_blank) ^ DP_INV;
      dig_d  = dig_hot ^ DIG_INV;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= '0;
         seg_q      <= SEG_INV;
         dp_q       <= DP_INV;
         dig_q      <= DIG_INV;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         dig_idx_q  <= dig_idx_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         dig_q      <= dig_d;
      end
   end

   assign seg_o = seg_q;
   assign dp_o  = dp_q;
   assign dig_o = dig_q;

endmodule

// File: tb/tb_io_panel_ctrl.sv
// tb_io_panel_ctrl
//   Self-checking bench for io_panel_ctrl. Cycle n is the interval after
//   rising edge n counted from reset release (n = 0 is the first cycle out of
//   reset). Inputs are driven 1 time unit after the edge, outputs are read on
//   the falling edge.
module tb_io_panel_ctrl;

   localparam int N_BTN = 5;
   localparam int N_DIG = 4;
   localparam int DB    = 8;
   localparam int LONG  = 40;
   localparam int REP   = 10;
   localparam int SCAN  = 4;
   localparam int MAXC  = 16384;

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [N_BTN-1:0]   btn_r   = '0;
   logic [4*N_DIG-1:0] code_r  = '0;
   logic [N_DIG-1:0]   dp_r    = '0;
   logic [N_DIG-1:0]   blank_r = '0;
   logic [N_BTN-1:0]   btn_level, btn_press, btn_long;
   logic [6:0]         seg;
   logic               dp;
   logic [N_DIG-1:0]   dig;

   io_panel_ctrl #(
      .N_BTN(N_BTN), .N_DIG(N_DIG), .DB_CYC(DB), .LONG_CYC(LONG),
      .REPEAT_CYC(REP), .SCAN_CYC(SCAN), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .btn_i(btn_r), .seg_code_i(code_r), .dp_i(dp_r),
      .blank_i(blank_r), .btn_level_o(btn_level), .btn_press_o(btn_press),
      .btn_long_o(btn_long), .seg_o(seg), .dp_o(dp), .dig_o(dig)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int base  = 0;
   bit rel_req = 1'b0;
   bit sim_on  = 1'b0;

   logic [N_BTN-1:0]   hist [MAXC];
   logic [4*N_DIG-1:0] code_v = '0, p_code = '0;
   logic [N_DIG-1:0]   dp_v = '0, blank_v = '0, p_dp = '0, p_blank = '0;

   // reference model state
   logic [N_BTN-1:0] m_stable = '0;
   int               m_rise [N_BTN];

   logic [31:0] exp_q[$];
   logic [31:0] got_p0[$], got_l0[$], got_p4[$];
   int cnt2 = 0, cnt_p1 = 0, cnt_p3 = 0;

   typedef struct packed {
      logic [15:0] code;
      logic [3:0]  dpi;
      logic [3:0]  blank;
      logic [27:0] seg;    // expected active-high glyphs {d3,d2,d1,d0}
      logic [3:0]  edp;    // expected active-high dp per digit
   } dvec_t;
   dvec_t vecs [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   // Raw input level of a channel during cycle c; flops are held clear in reset.
   function automatic logic raw(input int c, input int ch);
      if (c < base) return 1'b0;
      return hist[c][ch];
   endfunction

   // Behavioural model: the debounced level flips when the last DB
   // synchronised samples (inputs of cycles c-3 .. c-2-DB) all disagree with
   // it; events are scheduled by the time elapsed since the accepted rise.
   task automatic check_all();
      int rel, d, sel;
      logic prev;
      bit all_diff;
      logic [N_BTN-1:0] e_prs, e_lng;
      logic [6:0] e_seg;
      logic e_dp;
      logic [N_DIG-1:0] e_dig, one;
      if (rst) return;
      rel   = cyc - base;
      e_prs = '0;
      e_lng = '0;
      for (int ch = 0; ch < N_BTN; ch++) begin
         prev     = m_stable[ch];
         all_diff = 1'b1;
         for (int j = 3; j <= 2 + DB; j++) if (raw(cyc - j, ch) == prev) all_diff = 1'b0;
         if (all_diff) begin
            m_stable[ch] = ~prev;
            if (!prev) m_rise[ch] = cyc;
         end
         d = cyc - m_rise[ch];
         if (m_stable[ch]) begin
            e_prs[ch] = (d == 0) || (d == LONG) || (d > LONG && ((d - LONG) % REP) == 0);
            e_lng[ch] = (d == LONG);
         end
      end
      chk("level", btn_level, m_stable);
      chk("press", btn_press, e_prs);
      chk("long", btn_long, e_lng);

      if (rel == 0) begin
         chk("seg_first", seg, 32'h7F);
         chk("dp_first", dp, 32'h1);
         chk("dig_first", dig, 32'hF);
      end else begin
         sel   = ((rel - 1) / SCAN) % N_DIG;
         e_seg = p_blank[sel] ? 7'h00 : GLYPH[p_code[4*sel +: 4]];
         e_seg = ~e_seg;
         e_dp  = ~(p_dp[sel] & ~p_blank[sel]);
         one   = 1;
         e_dig = ~(one << sel);
         chk("seg", seg, e_seg);
         chk("dp", dp, e_dp);
         chk("dig", dig, e_dig);
      end

      if (btn_press[0]) got_p0.push_back(rel);
      if (btn_long[0])  got_l0.push_back(rel);
      if (btn_press[4]) got_p4.push_back(rel);
      if (btn_level[2] | btn_press[2] | btn_long[2]) cnt2++;
      if (btn_press[1]) cnt_p1++;
      if (btn_press[3]) cnt_p3++;
      if (sim_on) begin
         chk("sim_press", btn_press[1], btn_press[3]);
         chk("sim_long", btn_long[1], btn_long[3]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input logic [N_BTN-1:0] b);
      @(posedge clk);
      cyc++;
      p_code  = code_r;
      p_dp    = dp_r;
      p_blank = blank_r;
      #1;
      if (rel_req) begin
         rst      = 1'b0;
         base     = cyc;
         rel_req  = 1'b0;
         m_stable = '0;
         for (int i = 0; i < N_BTN; i++) m_rise[i] = -100000;
      end
      btn_r   = b;
      code_r  = code_v;
      dp_r    = dp_v;
      blank_r = blank_v;
      hist[cyc] = b;
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset(input logic [N_BTN-1:0] b);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_level", btn_level, 32'h0);
      chk("rst_press", btn_press, 32'h0);
      chk("rst_long", btn_long, 32'h0);
      chk("rst_seg", seg, 32'h7F);
      chk("rst_dp", dp, 32'h1);
      chk("rst_dig", dig, 32'hF);
      tick(b);
      tick(b);
      rel_req = 1'b1;
      tick(b);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [N_BTN-1:0] rb;
      logic [6:0] es;
      logic edpv;
      logic [N_DIG-1:0] ed, one;
      int sel;

      vecs[0] = '{code: 16'hA5F0, dpi: 4'b0010, blank: 4'b0000,
                  seg: {7'h77, 7'h6D, 7'h71, 7'h3F}, edp: 4'b0010};
      vecs[1] = '{code: 16'hBD72, dpi: 4'b0101, blank: 4'b0000,
                  seg: {7'h7C, 7'h5E, 7'h07, 7'h5B}, edp: 4'b0101};
      vecs[2] = '{code: 16'h9C64, dpi: 4'b1000, blank: 4'b1000,
                  seg: {7'h00, 7'h39, 7'h7D, 7'h66}, edp: 4'b0000};
      for (int i = 0; i < N_BTN; i++) m_rise[i] = -100000;

      do_reset('0);

      // Button 0 held from cycle 100 through 169; its release is accepted
      // at 180, which cancels the repeat due in that cycle.
      got_p0.delete();
      got_l0.delete();
      repeat (99) tick('0);
      repeat (70) tick(5'b00001);
      repeat (60) tick('0);
      exp_q = '{32'd110, 32'd150, 32'd160, 32'd170};
      chk("hold_npress", got_p0.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_p0.size()) chk("hold_press_at", got_p0[i], exp_q[i]);
      chk("hold_nlong", got_l0.size(), 32'd1);
      if (got_l0.size() > 0) chk("hold_long_at", got_l0[0], 32'd150);

      // Short glitches on button 2 must never be accepted.
      cnt2 = 0;
      repeat (8) begin
         repeat (5) tick(5'b00100);
         repeat (3) tick('0);
      end
      repeat (20) tick('0);
      chk("glitch_activity", cnt2, 32'd0);

      // Buttons 1 and 3 pressed together: rise, long, repeats at +50 and +60.
      cnt_p1 = 0;
      cnt_p3 = 0;
      sim_on = 1'b1;
      repeat (65) tick(5'b01010);
      repeat (20) tick('0);
      sim_on = 1'b0;
      chk("sim_npress1", cnt_p1, 32'd4);
      chk("sim_npress3", cnt_p3, 32'd4);

      // Display vectors.
      for (int v = 0; v < 3; v++) begin
         code_v  = vecs[v].code;
         dp_v    = vecs[v].dpi;
         blank_v = vecs[v].blank;
         tick('0);
         repeat (16) begin
            tick('0);
            sel  = ((cyc - base - 1) / SCAN) % N_DIG;
            es   = vecs[v].seg[7*sel +: 7];
            es   = ~es;
            edpv = ~vecs[v].edp[sel];
            one  = 1;
            ed   = ~(one << sel);
            chk("vec_seg", seg, es);
            chk("vec_dp", dp, edpv);
            chk("vec_dig", dig, ed);
         end
      end

      // Randomised buttons and display inputs against the model.
      rb = '0;
      repeat (2500) begin
         for (int ch = 0; ch < N_BTN; ch++)
            if ($urandom_range(0, 24) == 0) rb[ch] = ~rb[ch];
         code_v  = 16'($urandom);
         dp_v    = 4'($urandom);
         blank_v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         tick(rb);
      end

      // Reset while button 4 is in the repeat phase; the still-held button
      // must be accepted again as a new press after the debounce delay.
      code_v  = 16'h1234;
      dp_v    = '0;
      blank_v = '0;
      repeat (30) tick('0);
      repeat (60) tick(5'b10000);
      do_reset(5'b10000);
      got_p4.delete();
      repeat (30) tick(5'b10000);
      chk("rst_repress_n", (got_p4.size() > 0), 32'd1);
      if (got_p4.size() > 0) chk("rst_repress_at", got_p4[0], 32'd10);
      repeat (5) tick('0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
